// File: rtl/rv_int_pkg.sv
// Shared opcode/funct constants, ALU operation enum and the instruction decoder
// used by the rv_int_core integer pipeline.
package rv_int_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_XOR,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rs2;
        logic [11:0] imm;
        logic        illegal;
    } dec_t;

    function automatic logic f3_ok(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
               (f3 == F3_OR)  || (f3 == F3_AND);
    endfunction

    function automatic alu_op_e f3_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Register-index range checks depend on NREGS and are done by the caller.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3        = instr[14:12];
        f7        = instr[31:25];
        d.op      = ALU_ADD;
        d.rd      = instr[11:7];
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.imm     = instr[31:20];
        d.use_rs2 = 1'b0;
        d.illegal = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                d.op      = f3_op(f3);
                d.illegal = !f3_ok(f3);
            end
            OPC_OP: begin
                d.use_rs2 = 1'b1;
                if (f7 == F7_BASE) begin
                    d.op      = f3_op(f3);
                    d.illegal = !f3_ok(f3);
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    d.op = ALU_SUB;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_int_alu.sv
// Combinational integer ALU: wrapping add/sub, signed set-less-than and bitwise ops.
module rv_int_alu
    import rv_int_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_XOR: result = a ^ b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rv_int_core.sv
// Two-stage RV32I-subset integer core (decode/read, execute/writeback) with retire stream.
// Define RV_INT_FORWARD_EN to bypass the X-stage result instead of stalling on RAW hazards.
module rv_int_core
    import rv_int_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     instr_valid,
    input  logic [31:0]              instr_in,
    output logic                     instr_ready,
    output logic                     retire_valid,
    output logic [4:0]               retire_rd,
    output logic [XLEN-1:0]          retire_data,
    output logic                     illegal,
    input  logic [$clog2(NREGS)-1:0] dbg_raddr,
    output logic [XLEN-1:0]          dbg_rdata
);

    localparam int RW = $clog2(NREGS);

    dec_t            dec;
    logic            range_bad;
    logic            accept;
    logic            hazard;
    logic            fwd_rs1;
    logic            fwd_rs2;
    logic            x_live;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    logic [XLEN-1:0] rf_q  [1:NREGS-1];
    logic [XLEN-1:0] rf_rd [NREGS];

    logic            x_valid_q, x_valid_d;
    logic            x_ill_q, x_ill_d;
    alu_op_e         x_op_q, x_op_d;
    logic [4:0]      x_rd_q, x_rd_d;
    logic [XLEN-1:0] x_a_q, x_a_d;
    logic [XLEN-1:0] x_b_q, x_b_d;
    logic            ret_valid_q, ret_valid_d;
    logic [4:0]      ret_rd_q, ret_rd_d;
    logic [XLEN-1:0] ret_data_q, ret_data_d;

    assign dec = decode(instr_in);

    // With 32 registers every 5-bit index is in range.
    if (RW < 5) begin : g_range
        assign range_bad = (|dec.rd[4:RW]) | (|dec.rs1[4:RW]) |
                           (dec.use_rs2 & (|dec.rs2[4:RW]));
    end else begin : g_norange
        assign range_bad = 1'b0;
    end

    // An X-stage instruction that will write a nonzero register this cycle.
    assign x_live = x_valid_q & ~x_ill_q & (x_rd_q != 5'd0);

`ifdef RV_INT_FORWARD_EN
    assign fwd_rs1 = x_live & (x_rd_q == dec.rs1);
    assign fwd_rs2 = x_live & dec.use_rs2 & (x_rd_q == dec.rs2);
    assign hazard  = 1'b0;
`else
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
    assign hazard  = x_live & ((x_rd_q == dec.rs1) | (dec.use_rs2 & (x_rd_q == dec.rs2)));
`endif

    assign instr_ready = en & ~rst & ~hazard;
    assign accept      = instr_valid & instr_ready;

    assign imm_sext = {{(XLEN-12){dec.imm[11]}}, dec.imm};
    assign op_a     = fwd_rs1 ? alu_res : rf_rd[dec.rs1[RW-1:0]];
    assign op_b     = !dec.use_rs2 ? imm_sext :
                      fwd_rs2      ? alu_res  : rf_rd[dec.rs2[RW-1:0]];

    rv_int_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op    (x_op_q),
        .a     (x_a_q),
        .b     (x_b_q),
        .result(alu_res)
    );

    always_comb begin
        x_valid_d   = x_valid_q;
        x_ill_d     = x_ill_q;
        x_op_d      = x_op_q;
        x_rd_d      = x_rd_q;
        x_a_d       = x_a_q;
        x_b_d       = x_b_q;
        ret_valid_d = ret_valid_q;
        ret_rd_d    = ret_rd_q;
        ret_data_d  = ret_data_q;
        if (en) begin
            x_valid_d = accept;
            if (accept) begin
                x_ill_d = dec.illegal | range_bad;
                x_op_d  = dec.op;
                x_rd_d  = dec.rd;
                x_a_d   = op_a;
                x_b_d   = op_b;
            end
            ret_valid_d = x_valid_q & ~x_ill_q;
            if (x_valid_q && !x_ill_q) begin
                ret_rd_d   = x_rd_q;
                ret_data_d = alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid_q   <= 1'b0;
            x_ill_q     <= 1'b0;
            x_op_q      <= ALU_ADD;
            x_rd_q      <= '0;
            x_a_q       <= '0;
            x_b_q       <= '0;
            ret_valid_q <= 1'b0;
            ret_rd_q    <= '0;
            ret_data_q  <= '0;
        end else begin
            x_valid_q   <= x_valid_d;
            x_ill_q     <= x_ill_d;
            x_op_q      <= x_op_d;
            x_rd_q      <= x_rd_d;
            x_a_q       <= x_a_d;
            x_b_q       <= x_b_d;
            ret_valid_q <= ret_valid_d;
            ret_rd_q    <= ret_rd_d;
            ret_data_q  <= ret_data_d;
        end
    end

    // x0 has no storage; the read view ties it to zero.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
        if (gi == 0) begin : g_zero
            assign rf_rd[gi] = '0;
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    rf_q[gi] <= '0;
                end else if (en && x_live && x_rd_q == 5'(gi)) begin
                    rf_q[gi] <= alu_res;
                end
            end
            assign rf_rd[gi] = rf_q[gi];
        end
    end

    assign retire_valid = ret_valid_q & en;
    assign retire_rd    = ret_rd_q;
    assign retire_data  = ret_data_q;
    assign illegal      = x_valid_q & x_ill_q & en;
    assign dbg_rdata    = rf_rd[dbg_raddr];

endmodule

// File: tb/tb_rv_int_core.sv
// Directed self-checking bench for rv_int_core: a default 32x32 build and a 16-bit/8-register build.
`timescale 1ns/1ps
module tb_rv_int_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;

    logic        a_valid = 1'b0;
    logic [31:0] a_instr = '0;
    logic        a_ready;
    logic        a_ret_valid;
    logic [4:0]  a_ret_rd;
    logic [31:0] a_ret_data;
    logic        a_illegal;
    logic [4:0]  a_dbg = '0;
    logic [31:0] a_dbg_data;

    logic        b_valid = 1'b0;
    logic [31:0] b_instr = '0;
    logic        b_ready;
    logic        b_ret_valid;
    logic [4:0]  b_ret_rd;
    logic [15:0] b_ret_data;
    logic        b_illegal;
    logic [2:0]  b_dbg = '0;
    logic [15:0] b_dbg_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_ret_cnt = 0, a_ill_cnt = 0, a_ret_last = 0, a_ret_prev = 0;
    logic [4:0]  a_last_rd = '0;
    logic [31:0] a_last_data = '0;
    int b_ret_cnt = 0, b_ill_cnt = 0;
    logic [15:0] b_last_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_int_core #(.XLEN(32), .NREGS(32)) u_dut_a (
        .clk(clk), .rst(rst), .en(en),
        .instr_valid(a_valid), .instr_in(a_instr), .instr_ready(a_ready),
        .retire_valid(a_ret_valid), .retire_rd(a_ret_rd), .retire_data(a_ret_data),
        .illegal(a_illegal), .dbg_raddr(a_dbg), .dbg_rdata(a_dbg_data)
    );

    rv_int_core #(.XLEN(16), .NREGS(8)) u_dut_b (
        .clk(clk), .rst(rst), .en(en),
        .instr_valid(b_valid), .instr_in(b_instr), .instr_ready(b_ready),
        .retire_valid(b_ret_valid), .retire_rd(b_ret_rd), .retire_data(b_ret_data),
        .illegal(b_illegal), .dbg_raddr(b_dbg), .dbg_rdata(b_dbg_data)
    );

    always @(negedge clk) begin
        if (a_ret_valid) begin
            a_ret_cnt++;
            a_ret_prev  = a_ret_last;
            a_ret_last  = cyc;
            a_last_rd   = a_ret_rd;
            a_last_data = a_ret_data;
        end
        if (a_illegal) a_ill_cnt++;
        if (b_ret_valid) begin
            b_ret_cnt++;
            b_last_data = b_ret_data;
        end
        if (b_illegal) b_ill_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction and hold it until accepted; returns the stall cycles seen.
    task automatic issue(input bit sel, input logic [31:0] ins, output int stalls);
        stalls = 0;
        if (sel) begin b_valid = 1'b1; b_instr = ins; end
        else     begin a_valid = 1'b1; a_instr = ins; end
        #1;
        while (!(sel ? b_ready : a_ready) && stalls < 20) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 20) check_val("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        $display("issue dut=%0d instr=%08h stalls=%0d cyc=%0d", sel, ins, stalls, cyc);
    endtask

    task automatic dbg_check(input bit sel, input int addr, input logic [63:0] exp, input string tag);
        if (sel) b_dbg = 3'(addr);
        else     a_dbg = 5'(addr);
        #1;
        check_val(tag, sel ? 64'(b_dbg_data) : 64'(a_dbg_data), exp);
    endtask

    initial begin
        int st;
        int r0;
        int i0;
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, st2, r0, i0;
        // Reset
        step(2);
        check_val("ready_in_reset", 64'(a_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("ready_after_reset", 64'(a_ready), 64'd1);
        check_val("retire_valid_rst", 64'(a_ret_valid), 64'd0);
        check_val("illegal_rst", 64'(a_illegal), 64'd0);
        check_val("retire_rd_rst", 64'(a_ret_rd), 64'd0);
        check_val("retire_data_rst", 64'(a_ret_data), 64'd0);
        dbg_check(0, 1, 64'd0, "x1_rst");

        // Basic sequence
        r0 = a_ret_cnt;
        issue(0, 32'h00400093, st);
        issue(0, 32'h00500113, st);
        issue(0, 32'h40110233, st);
        step(4);
        check_val("basic_retires", 64'(a_ret_cnt - r0), 64'd3);
        dbg_check(0, 1, 64'd4, "basic_x1");
        dbg_check(0, 2, 64'd5, "basic_x2");
        dbg_check(0, 4, 64'd1, "basic_x4_sub");
        issue(0, 32'h001222B3, st);
        step(3);
        dbg_check(0, 5, 64'd1, "slt_x5");
        check_val("slt_ret_rd", 64'(a_last_rd), 64'd5);
        check_val("slt_ret_data", 64'(a_last_data), 64'd1);

        // RAW hazard
        issue(0, 32'h00700093, st);
        issue(0, 32'h001081B3, st2);
        step(4);
        dbg_check(0, 3, 64'd14, "raw_x3");
        check_val("raw_ret_data", 64'(a_last_data), 64'd14);
`ifdef RV_INT_FORWARD_EN
        check_val("raw_stalls", 64'(st2), 64'd0);
        check_val("raw_retire_gap", 64'(a_ret_last - a_ret_prev), 64'd1);
`else
        check_val("raw_stalls", 64'(st2), 64'd1);
        check_val("raw_retire_gap", 64'(a_ret_last - a_ret_prev), 64'd2);
`endif

        // x0 write
        r0 = a_ret_cnt;
        issue(0, 32'h00500013, st);
        step(3);
        check_val("x0_retires", 64'(a_ret_cnt - r0), 64'd1);
        check_val("x0_ret_rd", 64'(a_last_rd), 64'd0);
        check_val("x0_ret_data", 64'(a_last_data), 64'd5);
        dbg_check(0, 0, 64'd0, "x0_reads_zero");

        // Illegal (ECALL)
        r0 = a_ret_cnt;
        i0 = a_ill_cnt;
        issue(0, 32'h00000073, st);
        check_val("ecall_illegal_pulse", 64'(a_illegal), 64'd1);
        step(1);
        check_val("ecall_illegal_clear", 64'(a_illegal), 64'd0);
        step(2);
        check_val("ecall_no_retire", 64'(a_ret_cnt - r0), 64'd0);
        check_val("ecall_ill_count", 64'(a_ill_cnt - i0), 64'd1);
        dbg_check(0, 1, 64'd7, "ecall_x1_kept");
        dbg_check(0, 3, 64'd14, "ecall_x3_kept");

        // en low for 3 cycles with work in flight and a waiting instruction
        r0 = a_ret_cnt;
        issue(0, 32'h00900313, st);
        en = 1'b0;
        a_valid = 1'b1;
        a_instr = 32'h00300393;
        a_dbg = 5'd6;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("en_low_ready", 64'(a_ready), 64'd0);
            check_val("en_low_retire", 64'(a_ret_valid), 64'd0);
            check_val("en_low_x6_unwritten", 64'(a_dbg_data), 64'd0);
            step(1);
        end
        check_val("en_low_no_retires", 64'(a_ret_cnt - r0), 64'd0);
        en = 1'b1;
        issue(0, 32'h00300393, st);
        step(4);
        check_val("en_resume_retires", 64'(a_ret_cnt - r0), 64'd2);
        dbg_check(0, 6, 64'd9, "en_resume_x6");
        dbg_check(0, 7, 64'd3, "en_resume_x7");

        // Reset mid-flight
        r0 = a_ret_cnt;
        issue(0, 32'h00400093, st);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        check_val("rstmid_no_retire", 64'(a_ret_cnt - r0), 64'd0);
        dbg_check(0, 1, 64'd0, "rstmid_x1");
        dbg_check(0, 3, 64'd0, "rstmid_x3");

        // 16-bit, 8-register build
        r0 = b_ret_cnt;
        issue(1, 32'hFFF00093, st);
        step(3);
        check_val("b_retires", 64'(b_ret_cnt - r0), 64'd1);
        dbg_check(1, 1, 64'hFFFF, "b_x1_neg1");
        check_val("b_ret_data", 64'(b_last_data), 64'hFFFF);
        r0 = b_ret_cnt;
        i0 = b_ill_cnt;
        issue(1, 32'h00100493, st);
        check_val("b_rd9_illegal", 64'(b_illegal), 64'd1);
        step(3);
        check_val("b_rd9_no_retire", 64'(b_ret_cnt - r0), 64'd0);
        check_val("b_rd9_ill_count", 64'(b_ill_cnt - i0), 64'd1);
        dbg_check(1, 1, 64'hFFFF, "b_x1_kept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_int_core.md
Name: rv_int_core

Overview:
- Parametrised successor to the single-cycle MAIN datapath.
- Accepts RV32I-style integer ALU instructions through a valid/ready stream.
- Two pipeline stages:
  - D: decode and register read.
  - X: execute and writeback.
- Parametrised register width and register count.
- Adds a retire stream, illegal-instruction flagging and a debug read port.

Parameters:
- XLEN, 32: datapath and register width. Legal values are 16 to 64. Immediates are sign-extended to XLEN.
- NREGS, 32: architectural register count. Must be a power of two, from 4 to 32. x0 is hard-wired to zero.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline enable. When low, all state is frozen.
- instr_valid  in  1  instr_in carries an instruction.
- instr_in  in  32  RV32 instruction word.
- instr_ready  out  1  core can accept an instruction this cycle.
- retire_valid  out  1  one-cycle pulse per completed legal instruction.
- retire_rd  out  5  destination index of the retired instruction.
- retire_data  out  XLEN  ALU result of the retired instruction.
- illegal  out  1  one-cycle pulse for a rejected instruction.
- dbg_raddr  in  $clog2(NREGS)  debug register index.
- dbg_rdata  out  XLEN  combinational read of the register file; x0 reads 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All registers are cleared to 0 and D/X valid flags are cleared.
  - retire_valid, illegal, retire_rd and retire_data are 0.
  - instr_ready is 0 during reset and 1 in the first cycle after it.
  - Reset mid-operation discards all in-flight instructions with no writeback.
- Accept rule: an instruction is accepted when instr_valid && instr_ready && en. It is captured into D at that edge.
- Supported instructions:
  - OP-IMM (0010011), funct3: ADDI 000, SLTI 010, XORI 100, ORI 110, ANDI 111.
  - OP (0110011), funct7 0000000: ADD 000, SLT 010, XOR 100, OR 110, AND 111.
  - OP with funct7 0100000 and funct3 000: SUB.
  - Everything else is illegal, including any rd/rs1/rs2 index >= NREGS.
- Illegal instructions:
  - illegal pulses high in the cycle after acceptance.
  - No writeback and no retire pulse.
- Arithmetic:
  - Two's complement, wrapping modulo 2^XLEN.
  - SLT/SLTI are signed compares; the result is 1 or 0, zero-extended.
- Latency:
  - Instruction accepted at edge E is executed in the following cycle.
  - Register file, retire_rd and retire_data are written at edge E+1.
  - retire_valid is high for exactly one cycle after E+1.
- Writes with rd=x0 are discarded, but the instruction still retires with retire_rd=0.
- Throughput: one instruction per cycle when no stall is required.
- Read-after-write between back-to-back instructions is handled per RV_INT_FORWARD_EN (below).
- en low:
  - instr_ready=0.
  - D/X contents are held and the register file is not written.
  - retire_valid and illegal are forced to 0.
  - The pipeline resumes unchanged when en returns high.
- A simultaneous writeback and dbg_raddr read of the same register returns the old value until the edge.

Optional Feature:
- RV_INT_FORWARD_EN defined:
  - The X-stage result is bypassed to operand reads of the instruction being accepted.
  - instr_ready is never dropped for hazards.
- RV_INT_FORWARD_EN undefined:
  - instr_ready=0 while the incoming rs1 or rs2 (for OP) equals a valid, nonzero X-stage rd.
  - This inserts exactly one bubble.
  - Results are identical with or without the macro; only timing differs.

Decomposition:
- Package rv_int_pkg holds:
  - Opcode constants: OPC_OP, OPC_OP_IMM.
  - funct3/funct7 constants.
  - ALU-op enum: ADD, SUB, SLT, XOR, OR, AND.
  - Decoded-instruction struct typedef.
- One sub-module, rv_int_alu:
  - Combinational.
  - Parametrised by XLEN.
  - Inputs are op, a and b; output is the result.

Test Plan:
- Basic sequence, one per cycle after reset: 00400093 (ADDI x1,x0,4), 00500113 (ADDI x2,x0,5), 40110233 (SUB x4,x2,x1).
  - Expect 3 retire pulses.
  - Final state via dbg: x1=4, x2=5, x4=1.
  - Then 001222B3 (SLT x5,x4,x1) -> x5=1.
- RAW hazard: 00700093 (ADDI x1,x0,7) immediately followed by 001081B3 (ADD x3,x1,x1).
  - Expect x3=14 in both builds.
  - With RV_INT_FORWARD_EN: retire pulses on consecutive cycles.
  - Without RV_INT_FORWARD_EN: instr_ready low for 1 cycle, pulses 2 cycles apart.
- x0 write: 00500013 (ADDI x0,x0,5) -> retire_valid=1, retire_rd=0, dbg x0 reads 0.
- Illegal and en control:
  - 00000073 (ECALL) -> illegal pulse, no retire, register file unchanged.
  - Drop en for 3 cycles mid-stream -> no retire while low, instr_ready=0, correct results after resume.
- Reset mid-flight: assert rst in the cycle after 00400093 is accepted -> no retire, x1=0 after reset.
- Parameter build XLEN=16, NREGS=8:
  - FFF00093 (ADDI x1,x0,-1) -> x1=0xFFFF.
  - Instruction with rd=9 -> illegal pulse.
